// File: rtl/alu_operand_stage.sv
// alu_operand_stage: operand-fetch stage in front of the ALU.
// Holds a 2**AW x WIDTH register file with R[0] hardwired to zero. It reads
// two sources, sign-extends the immediate, picks the second operand and
// registers {srca, srcb, f, storedata} into one output slot that uses a
// valid/ready handshake.
// Optional feature: define ALU_OPERAND_BYPASS_EN to forward a same-cycle
// writeback into the captured operands (write-before-read).
module alu_operand_stage #(
  parameter int WIDTH = 32,
  parameter int AW    = 5,
  parameter int IMM_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  input  logic [IMM_W-1:0] imm,
  input  logic             alusrc,
  input  logic [2:0]       alucontrol,
  input  logic             we3,
  input  logic [AW-1:0]    wa3,
  input  logic [WIDTH-1:0] wd3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] srca,
  output logic [WIDTH-1:0] srcb,
  output logic [2:0]       f,
  output logic [WIDTH-1:0] storedata,
  output logic             bad_op
);

  localparam int NREG = 1 << AW;

  typedef enum logic [2:0] {
    OP_AND = 3'd0,
    OP_OR  = 3'd1,
    OP_ADD = 3'd2,
    OP_SUB = 3'd6,
    OP_SLT = 3'd7
  } alu_op_e;

  logic [WIDTH-1:0] r_rf [NREG];

  logic             r_out_valid;
  logic [WIDTH-1:0] r_srca;
  logic [WIDTH-1:0] r_srcb;
  logic [2:0]       r_f;
  logic [WIDTH-1:0] r_storedata;
  logic             r_bad_op;

  logic             w_wb_en;
  logic             w_accept;
  logic [WIDTH-1:0] w_rd1;
  logic [WIDTH-1:0] w_rd2;
  logic [WIDTH-1:0] w_sext;
  logic [WIDTH-1:0] w_srcb_next;
  logic             w_legal;
  logic [2:0]       w_f_next;

  // The slot can take a new instruction when it is empty or being drained;
  // deliberately independent of in_valid so no combinational loop can form.
  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;
  assign w_wb_en  = we3 && (wa3 != '0);

  // Register file write port; writes to R[0] are dropped.
  // NOTE: the whole array is cleared on reset because the design requires
  // every register to read zero after reset; this rules out a plain RAM macro.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
    end else if (w_wb_en) begin
      r_rf[wa3] <= wd3;
    end
  end

  // Source reads, with optional forwarding of the concurrent writeback.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_rd1 = (ra1 == '0) ? '0 : r_rf[ra1];
    w_rd2 = (ra2 == '0) ? '0 : r_rf[ra2];
`ifdef ALU_OPERAND_BYPASS_EN
    if (w_wb_en && (wa3 == ra1)) w_rd1 = wd3;
    if (w_wb_en && (wa3 == ra2)) w_rd2 = wd3;
`else
    // Read-before-write: the captured value is the pre-write contents.
`endif
  end

  // Immediate extension and second-operand select.
  always_comb begin
    w_sext      = {{(WIDTH-IMM_W){imm[IMM_W-1]}}, imm};
    w_srcb_next = alusrc ? w_sext : w_rd2;
  end

  // Function-code screening: illegal codes degrade to ADD.
  always_comb begin
    w_legal  = 1'b0;
    w_f_next = OP_ADD;
    case (alucontrol)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: begin
        w_legal  = 1'b1;
        w_f_next = alucontrol;
      end
      default: begin
        w_legal  = 1'b0;
        w_f_next = OP_ADD;
      end
    endcase
  end

  // Output slot: load on accept, clear valid on drain, otherwise hold.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_srca      <= '0;
      r_srcb      <= '0;
      r_f         <= OP_ADD;
      r_storedata <= '0;
      r_bad_op    <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_srca      <= w_rd1;
      r_srcb      <= w_srcb_next;
      r_f         <= w_f_next;
      r_storedata <= w_rd2;
      if (!w_legal) r_bad_op <= 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign srca      = r_srca;
  assign srcb      = r_srcb;
  assign f         = r_f;
  assign storedata = r_storedata;
  assign bad_op    = r_bad_op;

endmodule
